// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with 2-entry skid buffer; in_ready is decoded from local state only.
// Flush empties the stage to a bubble (NOP payload); stall/bubble counters saturate.
module pipe_stage_skid #(
  parameter int                DATA_W   = 32,
  parameter logic [31:0]       PC_RESET = 32'h00003000,
  parameter logic [DATA_W-1:0] NOP_VAL  = {DATA_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc4,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc4,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [31:0]         main_pc4_q, main_pc4_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic                main_bd_q, main_bd_d;
  logic [31:0]         skid_pc4_q, skid_pc4_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                skid_bd_q, skid_bd_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
  logic                accept, drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    state_d      = state_q;
    main_pc4_d   = main_pc4_q;
    main_data_d  = main_data_q;
    main_bd_d    = main_bd_q;
    skid_pc4_d   = skid_pc4_q;
    skid_data_d  = skid_data_q;
    skid_bd_d    = skid_bd_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    // Counters look at this cycle's outputs, independent of flush.
    if (out_valid_q && !out_ready && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (!out_valid_q && bubble_cnt_q != CNT_MAX)
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;

    if (flush) begin
      // Incoming entry is dropped; out_pc4 keeps its last value.
      state_d     = ST_EMPTY;
      main_data_d = NOP_VAL;
      main_bd_d   = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_pc4_d  = in_pc4;
            main_data_d = in_data;
            main_bd_d   = in_bd;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && drain) begin
            main_pc4_d  = in_pc4;
            main_data_d = in_data;
            main_bd_d   = in_bd;
          end else if (accept) begin
            skid_pc4_d  = in_pc4;
            skid_data_d = in_data;
            skid_bd_d   = in_bd;
            state_d     = ST_SKID;
          end else if (drain) begin
            main_data_d = NOP_VAL;
            main_bd_d   = 1'b0;
            state_d     = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (drain) begin
            main_pc4_d  = skid_pc4_q;
            main_data_d = skid_data_q;
            main_bd_d   = skid_bd_q;
            state_d     = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      main_pc4_q   <= PC_RESET;
      main_data_q  <= NOP_VAL;
      main_bd_q    <= 1'b0;
      skid_pc4_q   <= 32'h0;
      skid_data_q  <= {DATA_W{1'b0}};
      skid_bd_q    <= 1'b0;
      stall_cnt_q  <= {CNT_W{1'b0}};
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      main_pc4_q   <= main_pc4_d;
      main_data_q  <= main_data_d;
      main_bd_q    <= main_bd_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_data_q  <= skid_data_d;
      skid_bd_q    <= skid_bd_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_pc4    = main_pc4_q;
  assign out_data   = main_data_q;
  assign out_bd     = main_bd_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances (defaults, and CNT_W=4 with a non-zero NOP) share stimulus;
// a queue-based model predicts outputs every cycle, plus directed literal checks.
module tb_pipe_stage_skid;

  localparam logic [31:0] NOP2 = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, in_bd = 1'b0;
  logic [31:0] in_pc4 = 32'h0, in_data = 32'h0;

  logic        a_in_ready, a_out_valid, a_out_bd;
  logic [31:0] a_out_pc4, a_out_data;
  logic [15:0] a_stall, a_bubble;
  logic        b_in_ready, b_out_valid, b_out_bd;
  logic [31:0] b_out_pc4, b_out_data;
  logic [3:0]  b_stall, b_bubble;

  always #5 clk = ~clk;

  pipe_stage_skid u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_pc4(in_pc4), .in_data(in_data), .in_bd(in_bd),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc4(a_out_pc4), .out_data(a_out_data),
    .out_bd(a_out_bd), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
  );

  pipe_stage_skid #(.CNT_W(4), .NOP_VAL(NOP2)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_pc4(in_pc4), .in_data(in_data), .in_bd(in_bd),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc4(b_out_pc4), .out_data(b_out_data),
    .out_bd(b_out_bd), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
  );

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] data;
    logic        bd;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc4;
  logic [15:0] m_stall, m_bubble;
  logic [3:0]  m_stall4, m_bubble4;
  bit          model_ok = 1'b0;
  bit          m_v, m_rdy;
  logic        e_v, e_rdy, e_bd;
  logic [31:0] e_data;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the stage is a FIFO of depth 2; out_pc4 sticks at the last head's pc4.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_pc4 = 32'h00003000;
      m_stall = 0; m_bubble = 0; m_stall4 = 0; m_bubble4 = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_v   = (mq.size() > 0);
      m_rdy = (mq.size() < 2);
      if (m_v && !out_ready) begin
        if (m_stall  != 16'hFFFF) m_stall++;
        if (m_stall4 != 4'hF)     m_stall4++;
      end
      if (!m_v) begin
        if (m_bubble  != 16'hFFFF) m_bubble++;
        if (m_bubble4 != 4'hF)     m_bubble4++;
      end
      if (flush) mq.delete();
      else begin
        if (m_v && out_ready) void'(mq.pop_front());
        if (in_valid && m_rdy) mq.push_back('{pc4: in_pc4, data: in_data, bd: in_bd});
      end
      if (mq.size() > 0) m_pc4 = mq[0].pc4;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      e_v    = (mq.size() > 0);
      e_rdy  = (mq.size() < 2);
      e_data = e_v ? mq[0].data : 32'h0;
      e_bd   = e_v ? mq[0].bd : 1'b0;
      chk("a_out_valid", {31'b0, a_out_valid}, {31'b0, e_v});
      chk("a_in_ready",  {31'b0, a_in_ready},  {31'b0, e_rdy});
      chk("a_out_pc4",   a_out_pc4, m_pc4);
      chk("a_out_data",  a_out_data, e_data);
      chk("a_out_bd",    {31'b0, a_out_bd}, {31'b0, e_bd});
      chk("a_stall",     {16'b0, a_stall}, {16'b0, m_stall});
      chk("a_bubble",    {16'b0, a_bubble}, {16'b0, m_bubble});
      chk("b_out_valid", {31'b0, b_out_valid}, {31'b0, e_v});
      chk("b_in_ready",  {31'b0, b_in_ready},  {31'b0, e_rdy});
      chk("b_out_pc4",   b_out_pc4, m_pc4);
      chk("b_out_data",  b_out_data, e_v ? e_data : NOP2);
      chk("b_out_bd",    {31'b0, b_out_bd}, {31'b0, e_bd});
      chk("b_stall",     {28'b0, b_stall}, {28'b0, m_stall4});
      chk("b_bubble",    {28'b0, b_bubble}, {28'b0, m_bubble4});
    end
  end

  task automatic step(input logic r, input logic fl, input logic iv, input logic [31:0] d,
                      input logic ordy);
    #1;
    rst = r; flush = fl; in_valid = iv; in_data = d;
    in_pc4 = 32'h00400000 + (d << 2);
    in_bd = d[0];
    out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset, then idle
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("rst_pc4",    a_out_pc4, 32'h00003000);
    chk("rst_data",   a_out_data, 32'h0);
    chk("rst_valid",  {31'b0, a_out_valid}, 32'h0);
    chk("rst_ready",  {31'b0, a_in_ready}, 32'h1);
    chk("rst_bubble", {16'b0, a_bubble}, 32'h3);
    chk("rst_b_data", b_out_data, NOP2);

    // Back-to-back flow
    step(0, 0, 1, 32'hA, 1);
    chk("b2b_A", a_out_data, 32'hA); chk("b2b_rdyA", {31'b0, a_in_ready}, 32'h1);
    step(0, 0, 1, 32'hB, 1);
    chk("b2b_B", a_out_data, 32'hB); chk("b2b_rdyB", {31'b0, a_in_ready}, 32'h1);
    step(0, 0, 1, 32'hC, 1);
    chk("b2b_C", a_out_data, 32'hC); chk("b2b_rdyC", {31'b0, a_in_ready}, 32'h1);
    step(0, 0, 0, 0, 1);
    chk("b2b_empty", {31'b0, a_out_valid}, 32'h0);

    // Backpressure into skid, then release
    step(0, 0, 1, 32'h11, 0);
    chk("bp_11", a_out_data, 32'h11);
    step(0, 0, 1, 32'h22, 0);
    chk("bp_skid_rdy", {31'b0, a_in_ready}, 32'h0);
    step(0, 0, 1, 32'h33, 0);
    chk("bp_hold_rdy", {31'b0, a_in_ready}, 32'h0);
    chk("bp_hold_11", a_out_data, 32'h11);
    step(0, 0, 1, 32'h33, 1);
    chk("bp_22", a_out_data, 32'h22);
    step(0, 0, 1, 32'h33, 1);
    chk("bp_33", a_out_data, 32'h33);
    chk("bp_stall", {16'b0, a_stall}, 32'h2);
    step(0, 0, 0, 0, 1);
    chk("bp_empty", {31'b0, a_out_valid}, 32'h0);

    // Flush while in skid with a new offer
    step(0, 0, 1, 32'h55, 0);
    step(0, 0, 1, 32'h66, 0);
    chk("fl_skid", {31'b0, a_in_ready}, 32'h0);
    step(0, 1, 1, 32'h44, 0);
    chk("fl_valid", {31'b0, a_out_valid}, 32'h0);
    chk("fl_data",  a_out_data, 32'h0);
    chk("fl_bd",    {31'b0, a_out_bd}, 32'h0);
    chk("fl_ready", {31'b0, a_in_ready}, 32'h1);
    chk("fl_pc4",   a_out_pc4, 32'h00400154);
    chk("fl_b_nop", b_out_data, NOP2);
    chk("fl_stall", {16'b0, a_stall}, 32'h4);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("fl_no44", {31'b0, a_out_valid}, 32'h0);

    // Reset together with flush mid-skid
    step(0, 0, 1, 32'h77, 0);
    step(0, 0, 1, 32'h88, 0);
    step(1, 1, 1, 32'h99, 0);
    chk("rs_valid",  {31'b0, a_out_valid}, 32'h0);
    chk("rs_ready",  {31'b0, a_in_ready}, 32'h1);
    chk("rs_pc4",    a_out_pc4, 32'h00003000);
    chk("rs_data",   a_out_data, 32'h0);
    chk("rs_stall",  {16'b0, a_stall}, 32'h0);
    chk("rs_bubble", {16'b0, a_bubble}, 32'h0);
    chk("rs_b_stall", {28'b0, b_stall}, 32'h0);

    // Stall counter saturation on the 4-bit instance
    step(0, 0, 1, 32'h99, 0);
    repeat (20) step(0, 0, 0, 0, 0);
    chk("sat_b_stall", {28'b0, b_stall}, 32'hF);
    chk("sat_a_stall", {16'b0, a_stall}, 32'd20);
    step(0, 1, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 70));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
